// File: rtl/joypad_pkg.sv
// Shared types and constants for the NES-style joypad scanner.
//   state_e      : scan sequencer states
//   BTN_*        : bit positions of each button inside button_vec_t
//   button_vec_t : 8-bit button vector, 1 = pressed
package joypad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        WAIT   = 3'd2,
        CLK_HI = 3'd3,
        CLK_LO = 3'd4,
        FILTER = 3'd5
    } state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [7:0] button_vec_t;

endpackage

// File: rtl/joypad_filter.sv
// Scan-granularity debounce filter. A raw scan is published only after
// Stable consecutive identical scans.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   raw            : button vector of the scan just completed (1 = pressed)
//   strobe         : one-cycle pulse, raw is valid
//   buttons        : filtered button vector
//   changed        : one-cycle pulse on the cycle buttons takes a new value
module joypad_filter
    import joypad_pkg::*;
#(
    parameter int Stable = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  button_vec_t raw,
    input  logic        strobe,
    output button_vec_t buttons,
    output logic        changed
);

    // The match counter only has to reach Stable-1.
    localparam int CW = (Stable > 1) ? $clog2(Stable) : 1;
    localparam logic [CW-1:0] MatchMax = CW'(Stable - 1);

    logic [CW-1:0] match_q, match_d;
    button_vec_t   prev_q, prev_d;
    button_vec_t   buttons_q, buttons_d;
    logic          changed_q, changed_d;

    always_comb begin
        match_d   = match_q;
        prev_d    = prev_q;
        buttons_d = buttons_q;
        changed_d = 1'b0;
        if (strobe) begin
            if (raw == prev_q) begin
                match_d = (match_q == MatchMax) ? match_q : match_q + CW'(1);
            end else begin
                match_d = '0;
            end
            prev_d = raw;
            // Decision uses the freshly updated match count.
            if (match_d == MatchMax && raw != buttons_q) begin
                buttons_d = raw;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_q   <= '0;
            prev_q    <= 8'h00;
            buttons_q <= 8'h00;
            changed_q <= 1'b0;
        end else begin
            match_q   <= match_d;
            prev_q    <= prev_d;
            buttons_q <= buttons_d;
            changed_q <= changed_d;
        end
    end

    assign buttons = buttons_q;
    assign changed = changed_q;

endmodule

// File: rtl/joypad_scan.sv
// Periodic NES-style joypad scanner. Drives the pad latch/clock sequence,
// samples the 8 serial button bits and publishes a debounced, active-high
// button vector.
// Handshake: scan_req is a single-cycle request; requests and poll ticks
// arriving while a scan is pending or running collapse into one pending scan.
// Ports:
//   clock, reset_n : system clock, async active-low reset
//   pad_data       : serial pad data, active-low, asynchronous
//   scan_req       : one-cycle request for an immediate scan
//   pad_latch      : pad parallel-load strobe (registered)
//   pad_clock      : pad shift clock (registered)
//   buttons        : filtered buttons, bit 0..7 = A,B,Select,Start,Up,Down,Left,Right
//   changed        : one-cycle pulse when buttons updates
//   busy           : high in every state except IDLE
//   dbg_state      : current sequencer state
module joypad_scan
    import joypad_pkg::*;
#(
    parameter int PollPeriod = 200000,
    parameter int HalfBit    = 6,
    parameter int Stable     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pad_data,
    input  logic        scan_req,
    output logic        pad_latch,
    output logic        pad_clock,
    output button_vec_t buttons,
    output logic        changed,
    output logic        busy,
    output state_e      dbg_state
);

    localparam int PW  = (PollPeriod > 2) ? $clog2(PollPeriod) : 1;
    localparam int PhW = $clog2(2 * HalfBit);
    localparam logic [PW-1:0]  PollReload = PW'(PollPeriod - 1);
    localparam logic [PhW-1:0] LatchLast  = PhW'(2 * HalfBit - 1);
    localparam logic [PhW-1:0] HalfLast   = PhW'(HalfBit - 1);

    // Synchronizer resets to 1 so an idle line reads as released.
    logic [1:0]     sync_q;
    logic           raw_bit;
    logic [PW-1:0]  poll_q, poll_d;
    logic           poll_tick;
    logic           pending_q, pending_d;
    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [2:0]     bit_q, bit_d;
    button_vec_t    shift_q, shift_d;
    logic           latch_q, latch_d;
    logic           pclk_q, pclk_d;

    assign raw_bit = ~sync_q[1];

    // Free-running poll timer, independent of the sequencer.
    assign poll_tick = (poll_q == '0);
    assign poll_d    = poll_tick ? PollReload : poll_q - PW'(1);

    // New requests win over the IDLE consume so none is lost.
    assign pending_d = (pending_q && (state_q != IDLE)) || poll_tick || scan_req;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PhW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                bit_d   = 3'd0;
                if (pending_q) state_d = LATCH;
            end
            LATCH: begin
                if (phase_q == LatchLast) begin
                    state_d = WAIT;
                    phase_d = '0;
                end
            end
            WAIT: begin
                if (phase_q == HalfLast) begin
                    // Bits arrive A first; shifting right leaves A in bit 0.
                    shift_d = {raw_bit, shift_q[7:1]};
                    state_d = CLK_HI;
                    phase_d = '0;
                end
            end
            CLK_HI: begin
                if (phase_q == HalfLast) begin
                    state_d = CLK_LO;
                    phase_d = '0;
                end
            end
            CLK_LO: begin
                if (phase_q == HalfLast) begin
                    shift_d = {raw_bit, shift_q[7:1]};
                    phase_d = '0;
                    if (bit_q == 3'd6) begin
                        state_d = FILTER;
                    end else begin
                        state_d = CLK_HI;
                    end
                    bit_d = bit_q + 3'd1;
                end
            end
            FILTER: begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Pad strobes are registered copies of the next state, so they line up
    // exactly with the LATCH / CLK_HI states and can never overlap.
    assign latch_d = (state_d == LATCH);
    assign pclk_d  = (state_d == CLK_HI);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            poll_q    <= PollReload;
            pending_q <= 1'b0;
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pad_data};
            poll_q    <= poll_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            latch_q   <= latch_d;
            pclk_q    <= pclk_d;
        end
    end

    joypad_filter #(
        .Stable (Stable)
    ) u_filter (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (shift_q),
        .strobe  (state_q == FILTER),
        .buttons (buttons),
        .changed (changed)
    );

    assign pad_latch = latch_q;
    assign pad_clock = pclk_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_joypad_scan.sv
module tb_joypad_scan;
    import joypad_pkg::*;

    localparam int P        = 300;
    localparam int H        = 6;
    localparam int S        = 2;
    localparam int SCAN_LEN = 17 * H + 1;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pad_data;
    logic        scan_req = 1'b0;
    logic        pad_latch, pad_clock, changed, busy;
    button_vec_t buttons;
    state_e      dbg_state;

    always #5 clock = ~clock;

    joypad_scan #(
        .PollPeriod (P),
        .HalfBit    (H),
        .Stable     (S)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pad_data  (pad_data),
        .scan_req  (scan_req),
        .pad_latch (pad_latch),
        .pad_clock (pad_clock),
        .buttons   (buttons),
        .changed   (changed),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- pad model (4021-style shift register) ----------------
    logic [7:0] pad_byte = 8'hFF;   // active-low button levels
    bit         unplugged = 1'b0;
    int         pad_idx = 8;
    logic       pad_clk_prev = 1'b0;

    always @(negedge clock) begin
        if (pad_latch) pad_idx = 0;
        else if (pad_clock && !pad_clk_prev && pad_idx < 8) pad_idx++;
        pad_clk_prev = pad_clock;
    end

    assign pad_data = unplugged ? 1'b1 :
                      ((pad_idx < 8) ? pad_byte[pad_idx[2:0]] : 1'b1);

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] hist[$];
    logic [7:0] mdl_buttons;
    int passes = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(8'h00);
        mdl_buttons = 8'h00;
        exp_q.delete();
    endtask

    // Accept raw when the last S scans (history starts with a virtual 00)
    // are all identical and differ from the published value.
    task automatic model_scan(input logic [7:0] raw, output bit chg);
        bit agree;
        hist.push_back(raw);
        while (hist.size() > S) void'(hist.pop_front());
        agree = (hist.size() == S);
        foreach (hist[i]) if (hist[i] !== raw) agree = 0;
        chg = 0;
        if (agree && raw != mdl_buttons) begin
            mdl_buttons = raw;
            chg = 1;
        end
        exp_q.push_back(mdl_buttons);
    endtask

    // ---------------- driver: one full scan ----------------
    task automatic do_scan(input logic [7:0] pad_n, input bit req, input bit dbl_req,
                           output int wait_cnt);
        int len, latch_cnt, latch_late, clk_pulses, clk_hi, overlap, chg_in, run, bad_w;
        logic prev_clk;
        bit chg;
        pad_byte = pad_n;
        wait_cnt = 0;
        if (req) begin
            scan_req = 1'b1;
            @(negedge clock);
            scan_req = 1'b0;
            wait_cnt = 1;
        end
        while (!busy && wait_cnt < P + 50) begin
            @(negedge clock);
            wait_cnt++;
        end
        check("scan_start", 32'(busy), 32'd1);
        check("state_latch", 32'(dbg_state), 32'(LATCH));
        len = 0; latch_cnt = 0; latch_late = 0; clk_pulses = 0; clk_hi = 0;
        overlap = 0; chg_in = 0; run = 0; bad_w = 0; prev_clk = 1'b0;
        while (busy && len < 400) begin
            len++;
            if (pad_latch) latch_cnt++;
            if (pad_latch && len > 2 * H) latch_late++;
            if (pad_clock) begin
                clk_hi++;
                run++;
                if (!prev_clk) clk_pulses++;
            end else if (run != 0) begin
                if (run != H) bad_w++;
                run = 0;
            end
            if (pad_latch && pad_clock) overlap++;
            if (changed) chg_in++;
            prev_clk = pad_clock;
            scan_req = dbl_req && (len == 20 || len == 60);
            @(negedge clock);
        end
        scan_req = 1'b0;
        check("busy_len", len, SCAN_LEN);
        check("latch_len", latch_cnt, 2 * H);
        check("latch_order", latch_late, 0);
        check("clk_pulses", clk_pulses, 7);
        check("clk_high", clk_hi, 7 * H);
        check("clk_width", bad_w, 0);
        check("overlap", overlap, 0);
        check("changed_in_scan", chg_in, 0);
        model_scan(unplugged ? 8'h00 : ~pad_n, chg);
        check("buttons", 32'(buttons), 32'(exp_q.pop_front()));
        check("changed", 32'(changed), 32'(chg));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, n, rises;
        logic [7:0] v;
        bit quiet;
        logic prev;

        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_clock", 32'(pad_clock), 32'd0);
        check("rst_buttons", 32'(buttons), 32'h00);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;

        // A pressed: first scan holds 00, second publishes 01.
        do_scan(8'hFE, 0, 0, w);
        check("first_poll_delay", w, P + 1);
        do_scan(8'hFE, 0, 0, w);
        check("poll_spacing", w, P - SCAN_LEN);

        // Random patterns, each held for 1..3 scans.
        repeat (8) begin
            v = 8'($urandom);
            n = $urandom_range(1, 3);
            repeat (n) do_scan(v, 0, 0, w);
        end

        // Immediate request right after a scheduled scan.
        do_scan(8'hBF, 1, 0, w);
        check("req_latency", w, 2);

        // Two requests during a scan collapse into one back-to-back scan.
        do_scan(8'hBF, 0, 1, w);
        do_scan(8'hBF, 0, 0, w);
        check("back_to_back", w, 1);
        quiet = 1;
        repeat (20) begin
            @(negedge clock);
            if (busy) quiet = 0;
        end
        check("single_extra", 32'(quiet), 32'd1);

        // Make buttons non-zero, then abort a scan in CLK_HI of bit 4.
        do_scan(8'hF0, 0, 0, w);
        do_scan(8'hF0, 0, 0, w);
        scan_req = 1'b1;
        @(negedge clock);
        scan_req = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clock);
            n++;
        end
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 4 && n < 200) begin
            if (pad_clock && !prev) rises++;
            prev = pad_clock;
            if (rises < 4) @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("pre_reset_clk", 32'(pad_clock), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_clk_drop", 32'(pad_clock), 32'd0);
        check("async_latch_low", 32'(pad_latch), 32'd0);
        check("async_busy_low", 32'(busy), 32'd0);
        check("reset_buttons", 32'(buttons), 32'h00);
        model_reset();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Unplugged pad reads all released.
        unplugged = 1'b1;
        do_scan(8'hFE, 0, 0, w);
        check("poll_after_reset", w, P + 1);
        do_scan(8'hFE, 0, 0, w);
        do_scan(8'h00, 0, 0, w);
        unplugged = 1'b0;

        // Bouncing Right button never settles.
        for (int i = 0; i < 6; i++) begin
            do_scan((i % 2 == 0) ? 8'h7F : 8'hFF, 0, 0, w);
        end

        do_scan(8'hFE, 0, 0, w);
        do_scan(8'hFE, 0, 0, w);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
